// File: rtl/uart_frame_chk.sv
// UART receive frame checker: assembles one serial frame after start-bit detection
// and reports the data word, framing/parity/break flags and saturating error counts.
module uart_frame_chk #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 n_Rst,
  input  logic [1:0]           parity_mode,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 sbc_clear,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 break_detect,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_err_cnt,
  output logic [CNT_W-1:0]     parity_err_cnt
);

  localparam int BCW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [BCW-1:0]       bit_cnt;
  logic [1:0]           stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 acc;
  logic                 par_en, par_odd;
  logic                 par_err_p, frm_err_p, zero_p;
  logic                 done;
  logic                 frm_fin, zero_fin;

  // Results including the stop bit being strobed right now, so completion
  // can be registered on the same edge that consumes the last stop bit.
  assign frm_fin  = frm_err_p | ~bit_in;
  assign zero_fin = (stop_cnt == 2'd0) ? (zero_p & ~bit_in) : zero_p;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, otherwise paths
  // that do not assign it would infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:   if (frame_start) state_nxt = DATA;
      DATA:   if (bit_valid && bit_cnt == BCW'(DATA_BITS - 1))
                state_nxt = par_en ? PARITY : STOP;
      PARITY: if (bit_valid) state_nxt = STOP;
      STOP:   if (bit_valid && stop_cnt == 2'(STOP_BITS - 1)) begin
                state_nxt = IDLE;
                done      = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      shreg     <= '0;
      acc       <= 1'b0;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      par_err_p <= 1'b0;
      frm_err_p <= 1'b0;
      zero_p    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          bit_cnt   <= '0;
          stop_cnt  <= '0;
          acc       <= 1'b0;
          par_en    <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_odd   <= (parity_mode == 2'b10);
          par_err_p <= 1'b0;
          frm_err_p <= 1'b0;
          zero_p    <= 1'b1;
        end
        DATA: if (bit_valid) begin
          shreg   <= {bit_in, shreg[DATA_BITS-1:1]};
          acc     <= acc ^ bit_in;
          bit_cnt <= bit_cnt + BCW'(1);
          zero_p  <= zero_p & ~bit_in;
        end
        PARITY: if (bit_valid) begin
          par_err_p <= par_odd ? ~(acc ^ bit_in) : (acc ^ bit_in);
          zero_p    <= zero_p & ~bit_in;
        end
        STOP: if (bit_valid) begin
          stop_cnt  <= stop_cnt + 2'd1;
          frm_err_p <= frm_fin;
          zero_p    <= zero_fin;
        end
        default: ;
      endcase
    end
  end

  // Completion outputs; a coincident clear wins for flags and counters only.
  always_ff @(posedge clk or negedge n_Rst) begin
    if (!n_Rst) begin
      data_out       <= '0;
      data_valid     <= 1'b0;
      framing_error  <= 1'b0;
      parity_error   <= 1'b0;
      break_detect   <= 1'b0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
    end else begin
      data_valid <= done;
      if (done) data_out <= shreg;
      if (sbc_clear) begin
        framing_error  <= 1'b0;
        parity_error   <= 1'b0;
        break_detect   <= 1'b0;
        frame_err_cnt  <= '0;
        parity_err_cnt <= '0;
      end else if (done) begin
        framing_error <= frm_fin;
        parity_error  <= par_err_p;
        break_detect  <= zero_fin;
        if (frm_fin && frame_err_cnt != '1)
          frame_err_cnt <= frame_err_cnt + CNT_W'(1);
        if (par_err_p && parity_err_cnt != '1)
          parity_err_cnt <= parity_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/uart_frame_chk.md
Name: uart_frame_chk

Overview:
- Parametrised successor to the single-bit stop checker in the UART debugger receive path.
- Tracks one complete serial frame after start-bit detection: data bits, an optional parity bit, and 1 or 2 stop bits.
- Emits the assembled data word, per-frame framing, parity and break flags, and saturating error counters.
- Sits between the receive bit-timer/sampler and the receive FIFO/debug command decoder.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- CNT_W, 8, width of each error counter.

Ports:
- clk, in, 1, system clock; all state updates on rising edge.
- n_Rst, in, 1, asynchronous active-low reset.
- parity_mode, in, 2, 00 none, 01 even, 10 odd, 11 treated as none; latched at frame_start.
- frame_start, in, 1, single-cycle pulse from the sampler when a valid start bit is confirmed.
- bit_valid, in, 1, single-cycle strobe: bit_in holds a mid-bit sample.
- bit_in, in, 1, sampled serial bit.
- sbc_clear, in, 1, clears error flags and counters.
- data_out, out, DATA_BITS, last completed data word.
- data_valid, out, 1, one-cycle pulse when data_out and the flags update.
- framing_error, out, 1, last frame had a 0 in any stop-bit position.
- parity_error, out, 1, last frame failed the parity check.
- break_detect, out, 1, last frame had all data, parity (if enabled) and first stop bit equal to 0.
- busy, out, 1, high whenever state is not IDLE.
- frame_err_cnt, out, CNT_W, count of frames with framing_error.
- parity_err_cnt, out, CNT_W, count of frames with parity_error.

Behaviour:
- Reset (n_Rst low, asynchronous): state IDLE; all outputs, counters, shift register and bit counter are 0.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - frame_start → DATA; clears the bit counter and the parity accumulator; latches parity_mode.
  - bit_valid in IDLE is ignored, including when it coincides with frame_start.
- DATA:
  - Each bit_valid shifts bit_in into the MSB of the shift register (right shift) and XORs it into the accumulator.
  - After DATA_BITS strobes, the first data bit sits at data_out bit 0.
  - After the DATA_BITS-th strobe: → PARITY if the latched mode is even or odd, else → STOP.
- PARITY: on bit_valid, compute the pending error.
  - Even mode: error = acc XOR bit_in.
  - Odd mode: error = NOT(acc XOR bit_in).
  - Then → STOP.
- STOP:
  - Each bit_valid ORs (NOT bit_in) into the pending framing error.
  - On the STOP_BITS-th strobe: → IDLE.
  - On that same transition, register the completion updates.
- Completion updates (all visible the cycle after the last stop strobe):
  - data_valid = 1 for exactly one cycle.
  - data_out takes the new word.
  - framing_error, parity_error and break_detect are overwritten with this frame's results.
  - Each counter increments by 1 if its error is set.
- Latency: data_valid rises 1 clk after the final stop-bit bit_valid.
- Flags hold their values between completions; they are not self-clearing.
- break_detect implies framing_error = 1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- frame_start while not IDLE is ignored; the frame in progress continues.
- Only one bit is consumed per bit_valid; no two strobes arrive on consecutive cycles within the same bit period (sampler guarantee). The block itself does not rely on this spacing.
- sbc_clear:
  - Zeros all three flags and both counters next cycle.
  - Does not abort a frame, change state, or touch data_out.
  - Coincident with a completion: clear wins for flags and counters, but data_valid still pulses and data_out still updates.
- Reset mid-frame: immediate return to IDLE, all outputs 0, partial frame discarded, no data_valid.
- parity_mode changes mid-frame have no effect until the next frame_start.

Test Plan:
1. DATA_BITS=8, STOP_BITS=1, none; frame_start, then bits 1,0,1,0,0,1,0,1, stop 1 → data_valid 1 clk after stop strobe; data_out=0xA5; all flags 0; counters 0.
2. Even parity, data 0xA5 with parity bit 1 → parity_error=1, parity_err_cnt=1. Repeat with parity bit 0 → parity_error=0, count stays 1. Odd mode with parity 1 → no error.
3. STOP_BITS=2, data 0x3C, stops 1,0 → framing_error=1, frame_err_cnt=1, break_detect=0. Next frame with stops 1,1 → framing_error=0.
4. Break: 8 zero data bits, stop 0 → data_out=0x00, break_detect=1, framing_error=1.
5. CNT_W=2, four framing-error frames → frame_err_cnt reaches 3 and holds at 3. Then sbc_clear on the completion cycle of a fifth bad frame → counters and flags 0, data_valid still pulses.
6. Edge cases:
   - Assert n_Rst low after 4 data bits → busy=0, no data_valid; the next full frame decodes correctly.
   - frame_start during DATA → ignored.
   - bit_valid during IDLE → ignored.
